// File: rtl/alu_serial_seq_pkg.sv
// Shared encodings and helpers for the bit-serial ALU sequencer and its 1-bit slice.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_RSVD = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Ops that run the carry chain (the reserved code behaves as ADD).
    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_RSVD);
    endfunction

    function automatic logic needs_binvert(op_e op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic reports_carry(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Start/done handshake and operand/result bus between a datapath and the serial ALU.
interface alu_serial_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             clr;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry_out;
    logic             zero;

    modport master (
        output start, clr, op, a, b,
        input  busy, done, result, overflow, carry_out, zero
    );

    modport slave (
        input  start, clr, op, a, b,
        output busy, done, result, overflow, carry_out, zero
    );
endinterface

// File: rtl/alu_serial_seq_bit_core.sv
// Combinational 1-bit ALU slice; the sequencer feeds it one operand bit pair per clock.
module alu_bit_core
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic binvert,
    input  logic cin,
    input  op_e  op,
    input  logic is_msb,
    output logic res,
    output logic cout,
    output logic set,
    output logic ovf
);

    logic b_eff;
    logic sum;
    logic carry;

    assign b_eff = b ^ binvert;
    assign sum   = a ^ b_eff ^ cin;
    assign carry = (a & b_eff) | (cin & (a ^ b_eff));

    always_comb begin
        res  = 1'b0;
        cout = 1'b0;
        set  = 1'b0;
        ovf  = 1'b0;
        case (op)
            OP_AND:                  res = a & b;
            OP_OR:                   res = a | b;
            OP_NAND:                 res = ~(a & b);
            OP_NOR:                  res = ~(a | b);
            OP_ADD, OP_SUB, OP_RSVD: res = sum;
            default:                 res = 1'b0;
        endcase
        if (is_arith(op)) begin
            cout = carry;
        end
        // Set is the raw sign of the difference, with no overflow correction.
        if (is_msb) begin
            set = sum;
            if ((op == OP_ADD) || (op == OP_SUB)) begin
                ovf = cin ^ carry;
            end
        end
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one operand bit per clock, LSB first, through alu_bit_core.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_serial_seq_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             binvert;
    op_e              op_r;
    logic             ovf_q;
    logic             set_q;
    logic             cout_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             carry_out_q;
    logic             zero_q;

    logic             accept;
    logic             finish;
    logic             last_bit;
    logic             slice_res;
    logic             slice_cout;
    logic             slice_set;
    logic             slice_ovf;
    logic [WIDTH-1:0] final_res;

    assign last_bit  = (cnt == LAST);
    assign final_res = (op_r == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_q} : res_sh;

    alu_bit_core u_bit_core (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .binvert (binvert),
        .cin     (carry),
        .op      (op_r),
        .is_msb  (last_bit),
        .res     (slice_res),
        .cout    (slice_cout),
        .set     (slice_set),
        .ovf     (slice_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start is refused during the done cycle too, since busy is still high there.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.clr && !done_q) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                finish     = !bus.clr;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            binvert <= 1'b0;
            op_r    <= OP_AND;
            ovf_q   <= 1'b0;
            set_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            res_sh  <= '0;
            carry   <= needs_binvert(op_e'(bus.op));
            binvert <= needs_binvert(op_e'(bus.op));
            op_r    <= op_e'(bus.op);
        end else if ((state == RUN) && !bus.clr) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {slice_res, res_sh[WIDTH-1:1]};
            carry  <= slice_cout;
            if (last_bit) begin
                ovf_q  <= slice_ovf;
                set_q  <= slice_set;
                cout_q <= slice_cout & reports_carry(op_r);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Visible results move together, only in the cycle that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            done_q <= finish;
            if (finish) begin
                result_q    <= final_res;
                overflow_q  <= ovf_q;
                carry_out_q <= cout_q;
                zero_q      <= (final_res == '0);
            end
        end
    end

    assign bus.busy      = (state != IDLE) || done_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: reference results are queued at issue and popped at done.
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         cout;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t     e;
        logic [W:0] s;
        e.res  = '0;
        e.ovf  = 1'b0;
        e.cout = 1'b0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b011: e.res = ~(a & b);
            3'b100: e.res = ~(a | b);
            3'b010: begin
                s      = {1'b0, a} + {1'b0, b};
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b110: begin
                s      = {1'b0, a} + {1'b0, ~b} + 1;
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b111: begin
                s      = {1'b0, a} + {1'b0, ~b} + 1;
                e.res  = {{(W-1){1'b0}}, s[W-1]};
                e.cout = s[W];
            end
            default: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input string name, input int consumed);
        int   lat  = 0;
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = i + consumed;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no done, required done within 200 cycles", name);
            return;
        end
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d edges, required %0d", name, lat, W + 1);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard: got done with 0 entries queued, required 1", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.result !== e.res) begin
            errors++;
            $display("[TB] FAIL %s result: got %h required %h", name, bus.result, e.res);
        end
        checks++;
        if (bus.overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL %s overflow: got %b required %b", name, bus.overflow, e.ovf);
        end
        checks++;
        if (bus.carry_out !== e.cout) begin
            errors++;
            $display("[TB] FAIL %s carry_out: got %b required %b", name, bus.carry_out, e.cout);
        end
        checks++;
        if (bus.zero !== e.zero) begin
            errors++;
            $display("[TB] FAIL %s zero: got %b required %b", name, bus.zero, e.zero);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy_at_done: got %b required 1", name, bus.busy);
        end
        last_res = e.res;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s after_done busy/done: got %b required 00", name, {bus.busy, bus.done});
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.carry_out, bus.zero} !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset flags: got %b required 00001",
                     {bus.busy, bus.done, bus.overflow, bus.carry_out, bus.zero});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("[TB] FAIL reset result: got %h required 0", bus.result);
        end
    endtask

    task automatic test_arith();
        issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1); wait_done("add_ovf", 0);
        issue(3'b110, 32'd5, 32'd5, 1'b1);                 wait_done("sub_zero", 0);
        issue(3'b110, 32'h8000_0000, 32'd1, 1'b1);         wait_done("sub_ovf", 0);
        issue(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1);         wait_done("add_carry", 0);
    endtask

    task automatic test_slt();
        issue(3'b111, 32'd3, 32'd7, 1'b1);           wait_done("slt_lt", 0);
        issue(3'b111, 32'd7, 32'd3, 1'b1);           wait_done("slt_gt", 0);
        issue(3'b111, 32'hFFFF_FFFF, 32'd0, 1'b1);   wait_done("slt_neg", 0);
    endtask

    task automatic test_logic();
        issue(3'b100, 32'd0, 32'd0, 1'b1);                     wait_done("nor", 0);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);     wait_done("nand", 0);
        issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);     wait_done("and", 0);
        issue(3'b001, 32'h1234_0000, 32'h0000_5678, 1'b1);     wait_done("or", 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            issue(3'(k), $urandom, $urandom, 1'b1);
            wait_done("random", 0);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        issue(3'b010, 32'd100, 32'd23, 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        bus.op    = 3'b110;
        bus.a     = 32'h5555_0000;
        bus.b     = 32'h0000_1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("ignore_start", 10);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_start extra_done: got %0d required 0", dones);
        end
    endtask

    task automatic test_clr();
        int dones = 0;
        issue(3'b010, 32'hAAAA_AAAA, 32'h1111_1111, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL clr done_count: got %0d required 0", dones);
        end
        checks++;
        if (bus.result !== last_res) begin
            errors++;
            $display("[TB] FAIL clr result_hold: got %h required %h", bus.result, last_res);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr busy: got %b required 0", bus.busy);
        end
        bus.start = 1'b1;
        bus.clr   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_start_idle busy: got %b required 0", bus.busy);
        end
        issue(3'b010, 32'd40, 32'd2, 1'b1);
        wait_done("after_clr", 0);
    endtask

    task automatic test_async_reset();
        issue(3'b010, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.zero} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL async_reset busy/done/zero: got %b required 001",
                     {bus.busy, bus.done, bus.zero});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset result: got %h required 0", bus.result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'b010, 32'd2, 32'd3, 1'b1);
        wait_done("post_reset_add", 0);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_slt();
        test_logic();
        test_random();
        test_ignore_start();
        test_clr();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial sequencer that executes one full-width ALU operation by driving a single 1-bit ALU slice, one bit per clock, LSB first. It holds the carry between cycles, applies the Binvert/CarryIn policy for SUB/SLT, and treats the last bit as the MSB for overflow and the Set result. It gives the datapath a small-area, multi-cycle ALU with a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
clr  input  1  synchronous abort; returns to IDLE with no done
op  input  3  000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 110 SUB, 111 SLT, 101 reserved
a  input  WIDTH  operand A, latched at start
b  input  WIDTH  operand B, latched at start
busy  output  1  high while an operation is in flight (RUN, DONE)
done  output  1  one-cycle pulse: result and flags updated this cycle
result  output  WIDTH  registered result, held until next done
overflow  output  1  signed overflow (ADD/SUB only), held with result
carry_out  output  1  final MSB carry (ADD/SUB/SLT), else 0
zero  output  1  result == 0, held with result

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, overflow, carry_out = 0; result = 0; zero = 1; internal shift registers, counter and carry = 0.
- States: IDLE -> RUN on start=1. RUN -> DONE after bit WIDTH-1. DONE -> IDLE unconditionally. clr=1 in RUN or DONE -> IDLE: no done, outputs keep previous values. In DONE, clr has priority over done.
- Accept edge: latch a, b and op. Set bit counter to 0. Set carry = 1 for SUB/SLT, else 0. Set binvert = 1 for SUB/SLT.
- RUN: each cycle, process bit[cnt] through the slice and shift the sum/logic bit into the staging register MSB-side. Carry flop takes the slice CarryOut. Counter increments.
- Final bit (cnt = WIDTH-1):
  - overflow = CarryIn xor CarryOut, valid only for ADD/SUB.
  - set = MSB sum bit, plain sign bit, no overflow correction.
  - carry_out = final CarryOut for ADD/SUB/SLT.
- Latency: done is high in the cycle after the final-bit edge, exactly WIDTH+1 edges after the accept edge. busy falls the following cycle.
- SLT: result = {WIDTH-1 zeros, set}; overflow = 0.
- op 101: executes as ADD with binvert = 0; overflow forced to 0.
- Logic ops (AND/OR/NAND/NOR): overflow = 0, carry_out = 0.
- result, overflow, carry_out and zero update only in the DONE cycle, all together. Otherwise they hold.
- start while busy is ignored and not queued. start and clr together in IDLE: clr wins, start is dropped.
- Operand inputs may change freely after the accept edge.
- Counter width is clog2(WIDTH). No wrap: the terminal count forces the DONE transition.

Decomposition:
- Package alu_pkg holds:
  - op encodings: OP_AND, OP_OR, OP_ADD, OP_NAND, OP_NOR, OP_SUB, OP_SLT, OP_RSVD
  - state enum: IDLE, RUN, DONE
  - helpers is_arith(op) and needs_binvert(op)
- One sub-module, alu_bit_core: a combinational 1-bit slice with inputs a, b, binvert, cin, op and an is_msb flag. It produces res, cout, set, ovf. The sequencer owns all state.

Test Plan:
1. ADD a=0x7FFFFFFF, b=0x00000001 -> done after 33 edges; result=0x80000000, overflow=1, carry_out=0, zero=0.
2. SUB a=5, b=5 -> result=0, zero=1, carry_out=1, overflow=0. SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
3. SLT a=3, b=7 -> result=1. SLT a=7, b=3 -> result=0. SLT a=0xFFFFFFFF(-1), b=0 -> result=1. overflow=0 in all three.
4. NOR a=0, b=0 -> 0xFFFFFFFF. NAND a=b=0xFFFFFFFF -> 0, zero=1. AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0. In all cases overflow=0, carry_out=0.
5. Pulse start again at cycle 10 of an ADD with different operands -> ignored; single done with the first result. Assert clr at cycle 20 -> no done, result retains the prior value, next start is accepted normally.
6. Drop rst_n mid-RUN -> busy=0, done=0, result=0, zero=1 immediately. After release, an ADD 2+3 -> 5 with nominal latency.
